// File: rtl/step_input_ctrl.sv
// Synchronise, debounce and auto-repeat the up/down switches for the digit counter.
// Define STEP_AUTOREPEAT_EN for held-switch auto-repeat; otherwise one step per press.
module step_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic sw_up,
  input  logic sw_down,
  output logic step,
  output logic direction,
  output logic up_clean,
  output logic down_clean,
  output logic busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(REPEAT_DELAY + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_DELAY,
    S_REPEAT,
    S_LOCK
  } state_t;

  // Channel 1 is up, channel 0 is down.
  logic [1:0]    w_raw;
  logic [1:0]    r_s1;
  logic [1:0]    r_s2;
  logic [1:0]    r_clean;
  logic [CW-1:0] r_cnt [2];

  state_t r_state;
  logic   r_step;
  logic   r_dir;
  logic   r_busy;
  logic   w_act;
  logic   w_oth;

  assign w_raw      = {sw_up, sw_down};
  assign step       = r_step;
  assign direction  = r_dir;
  assign up_clean   = r_clean[1];
  assign down_clean = r_clean[0];
  assign busy       = r_busy;

  assign w_act = r_dir ? r_clean[1] : r_clean[0];
  assign w_oth = r_dir ? r_clean[0] : r_clean[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        r_cnt[i]   <= '0;
        r_clean[i] <= 1'b0;
      end else if (r_s2[i] == r_clean[i]) begin
        r_cnt[i] <= '0;
      end else if (r_cnt[i] == C_LAST) begin
        r_cnt[i]   <= '0;
        r_clean[i] <= ~r_clean[i];
      end else begin
        r_cnt[i] <= r_cnt[i] + CW'(1);
      end
    end
  end

`ifdef STEP_AUTOREPEAT_EN
  logic [TW-1:0] r_timer;
`else
  logic [TW-1:0] w_unused_rpt;
  assign w_unused_rpt = TW'(REPEAT_PERIOD);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_step  <= 1'b0;
      r_dir   <= 1'b1;
      r_busy  <= 1'b0;
`ifdef STEP_AUTOREPEAT_EN
      r_timer <= '0;
`endif
    end else begin
      r_step <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (r_clean[1] && r_clean[0]) begin
            r_state <= S_LOCK;
            r_busy  <= 1'b1;
          end else if (r_clean[1] || r_clean[0]) begin
            r_state <= S_FIRST;
            r_step  <= 1'b1;
            r_dir   <= r_clean[1];
            r_busy  <= 1'b1;
          end
        end
        S_LOCK: begin
          if (!r_clean[1] && !r_clean[0]) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          // A second switch wins over release so a crossover never steps.
          if (w_oth) begin
            r_state <= S_LOCK;
          end else if (!w_act) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_state == S_FIRST) begin
            r_state <= S_DELAY;
`ifdef STEP_AUTOREPEAT_EN
            r_timer <= TW'(1);
          end else if (r_state == S_DELAY) begin
            if (r_timer >= TW'(REPEAT_DELAY - 1)) begin
              r_state <= S_REPEAT;
              r_step  <= 1'b1;
              r_timer <= TW'(1);
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end else begin
            if (r_timer == TW'(REPEAT_PERIOD)) begin
              r_step  <= 1'b1;
              r_timer <= TW'(1);
            end else begin
              r_timer <= r_timer + TW'(1);
            end
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_input_ctrl.sv
// Directed and randomised checks of step_input_ctrl against a press-level model.
// Honours STEP_AUTOREPEAT_EN the same way as the design.
module tb_step_input_ctrl;

  localparam int D  = 4;
  localparam int RD = 16;
  localparam int RP = 4;
  localparam logic [31:0] MASK = (32'd1 << D) - 32'd1;

  logic clock = 1'b0;
  logic reset;
  logic sw_up;
  logic sw_down;
  logic step;
  logic direction;
  logic up_clean;
  logic down_clean;
  logic busy;

  always #5 clock = ~clock;

  step_input_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sw_up(sw_up),
    .sw_down(sw_down),
    .step(step),
    .direction(direction),
    .up_clean(up_clean),
    .down_clean(down_clean),
    .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // Model: sync delay, window-of-D debounce, and press-relative step times.
  bit m_s1u, m_s2u, m_s1d, m_s2d;
  bit m_cu, m_cd, m_dir, m_step, m_busy;
  logic [31:0] hu, hd;
  int nu, nd;
  int m_mode;
  int m_e = 0;
  int m_p;

  int nsteps;
  int first_step_edge;
  int last_step_edge;
  int busy_fall_edge;
  logic step_dir;
  logic prev_busy;
  logic seen_upclean;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit cu, cd, act, oth;
`ifdef STEP_AUTOREPEAT_EN
    int k;
`endif
    m_e++;
    if (reset) begin
      m_s1u = 0; m_s2u = 0; m_s1d = 0; m_s2d = 0;
      m_cu = 0; m_cd = 0; m_dir = 1; m_step = 0; m_busy = 0;
      hu = 0; hd = 0; nu = 0; nd = 0; m_mode = 0;
      return;
    end
    cu = m_cu;
    cd = m_cd;
    m_step = 0;
    case (m_mode)
      0: begin
        if (cu && cd) m_mode = 2;
        else if (cu ^ cd) begin
          m_mode = 1; m_dir = cu; m_p = m_e; m_step = 1;
        end
      end
      1: begin
        act = m_dir ? cu : cd;
        oth = m_dir ? cd : cu;
        if (oth) m_mode = 2;
        else if (!act) m_mode = 0;
        else begin
`ifdef STEP_AUTOREPEAT_EN
          k = m_e - m_p;
          if (k >= RD && (k - RD) % RP == 0) m_step = 1;
`endif
        end
      end
      default: if (!cu && !cd) m_mode = 0;
    endcase
    m_busy = (m_mode != 0);
    hu = {hu[30:0], m_s2u}; nu++;
    if (nu >= D && (hu & MASK) == (cu ? 32'd0 : MASK)) begin
      m_cu = !cu; nu = 0;
    end
    hd = {hd[30:0], m_s2d}; nd++;
    if (nd >= D && (hd & MASK) == (cd ? 32'd0 : MASK)) begin
      m_cd = !cd; nd = 0;
    end
    m_s2u = m_s1u; m_s1u = sw_up;
    m_s2d = m_s1d; m_s1d = sw_down;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    chk("step", {31'd0, step}, {31'd0, m_step});
    chk("direction", {31'd0, direction}, {31'd0, m_dir});
    chk("up_clean", {31'd0, up_clean}, {31'd0, m_cu});
    chk("down_clean", {31'd0, down_clean}, {31'd0, m_cd});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    if (step === 1'b1) begin
      nsteps++;
      last_step_edge = m_e;
      step_dir = direction;
      if (first_step_edge < 0) first_step_edge = m_e;
    end
    if (prev_busy === 1'b1 && busy === 1'b0) busy_fall_edge = m_e;
    prev_busy = busy;
    if (up_clean === 1'b1) seen_upclean = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_stats();
    nsteps = 0;
    first_step_edge = -1;
    last_step_edge = -1;
    busy_fall_edge = -1;
    seen_upclean = 1'b0;
  endtask

  initial begin
    int ke;
    int wait_n;
    int len;
    logic [5:0] bpat;
    reset = 1'b1;
    sw_up = 1'b1;
    sw_down = 1'b1;
    prev_busy = 1'b0;
    clr_stats();

    // Reset held with both switches pressed.
    run(3);
    chk("rst_step", {31'd0, step}, 32'd0);
    chk("rst_dir", {31'd0, direction}, 32'd1);
    reset = 1'b0;
    sw_up = 1'b0;
    sw_down = 1'b0;
    tick();
    chk("rst_busy_after", {31'd0, busy}, 32'd0);
    run(8);

    // Single up press.
    clr_stats();
    sw_up = 1'b1;
    ke = m_e + 1;
    run(12);
    sw_up = 1'b0;
    run(12);
    chk("up_nsteps", nsteps, 1);
    chk("up_step_edge", last_step_edge, ke + 6);
    chk("up_step_dir", {31'd0, step_dir}, 32'd1);
    chk("up_busy_fall", busy_fall_edge, ke + 11 + 7);

    // Bounce: never four consecutive highs.
    clr_stats();
    bpat = 6'b001101;
    for (int i = 0; i < 24; i++) begin
      sw_up = bpat[i % 6];
      tick();
    end
    sw_up = 1'b0;
    run(10);
    chk("bounce_nsteps", nsteps, 0);
    chk("bounce_clean", {31'd0, seen_upclean}, 32'd0);

    // Held down switch.
    clr_stats();
    sw_down = 1'b1;
    ke = m_e + 1;
    run(40);
    sw_down = 1'b0;
    run(14);
`ifdef STEP_AUTOREPEAT_EN
    chk("down_nsteps", nsteps, 7);
    chk("down_last_edge", last_step_edge, ke + 42);
`else
    chk("down_nsteps", nsteps, 1);
`endif
    chk("down_first_edge", first_step_edge, ke + 6);
    chk("down_dir", {31'd0, step_dir}, 32'd0);

    // Simultaneous press, staggered release.
    clr_stats();
    sw_up = 1'b1;
    sw_down = 1'b1;
    run(10);
    chk("sim_busy", {31'd0, busy}, 32'd1);
    sw_down = 1'b0;
    run(10);
    chk("sim_busy_hold", {31'd0, busy}, 32'd1);
    sw_up = 1'b0;
    run(12);
    chk("sim_nsteps", nsteps, 0);
    chk("sim_idle", {31'd0, busy}, 32'd0);
    clr_stats();
    sw_up = 1'b1;
    run(12);
    sw_up = 1'b0;
    run(12);
    chk("sim_after_nsteps", nsteps, 1);

    // Reset during repeat with up held.
    sw_up = 1'b1;
    run(30);
    reset = 1'b1;
    tick();
    chk("midrst_step", {31'd0, step}, 32'd0);
    reset = 1'b0;
    wait_n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (step === 1'b1) begin
        wait_n = i;
        break;
      end
    end
    chk("midrst_latency", wait_n, D + 3);
    sw_up = 1'b0;
    run(14);

    // Randomised switch activity.
    for (int s = 0; s < 60; s++) begin
      sw_up = 1'($urandom_range(0, 1));
      sw_down = 1'($urandom_range(0, 3) == 0);
      reset = 1'($urandom_range(0, 39) == 0);
      len = $urandom_range(1, 25);
      tick();
      reset = 1'b0;
      run(len);
    end
    sw_up = 1'b0;
    sw_down = 1'b0;
    run(14);
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/step_input_ctrl.md
# step_input_ctrl

Switch-conditioning stage that sits directly upstream of the decimal up/down counter. It synchronises and debounces two raw push-switch inputs (up, down). It emits single-cycle `step` pulses and a registered `direction` level, which drive the counter's count-enable and direction inputs. Holding a switch produces auto-repeat stepping, so the 7-segment digit can be scrolled without repeated presses.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised samples that must disagree with the current clean level before it flips; ≥1.
- `REPEAT_DELAY`, default 16: cycles from the first step to the first repeat step; ≥`REPEAT_PERIOD`.
- `REPEAT_PERIOD`, default 4: cycles between subsequent repeat steps; ≥1.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `sw_up`  in  1  raw, asynchronous, bouncy up switch.
- `sw_down`  in  1  raw, asynchronous, bouncy down switch.
- `step`  out  1  one-cycle pulse; counter advances one position.
- `direction`  out  1  1 = up, 0 = down; valid whenever `step` is high.
- `up_clean`  out  1  debounced level of `sw_up`.
- `down_clean`  out  1  debounced level of `sw_down`.
- `busy`  out  1  high while the FSM is outside IDLE.

## Operation
- Reset values: `step`=0, `direction`=1, `up_clean`=0, `down_clean`=0, `busy`=0. Synchronisers, debounce counters and repeat timer all clear to 0. FSM enters IDLE.
- Synchroniser: each raw input passes through 2 flops (s1, s2).
- Debounce, per channel:
  - The counter increments while s2 ≠ clean. It clears to 0 on any cycle where s2 = clean.
  - When the count reaches `DEBOUNCE_CYCLES`, clean flips and the counter clears on the same edge.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- FSM states: IDLE, FIRST, DELAY, REPEAT, LOCK.
  - IDLE → FIRST when exactly one clean level is high. `direction` latches 1 for up, 0 for down on this edge.
  - IDLE → LOCK when both clean levels are high.
  - FIRST: `step`=1 for this single cycle; timer loads 1. Then → DELAY.
  - DELAY: timer increments each cycle. On the edge where timer = `REPEAT_DELAY`-1, → REPEAT with `step`=1 next cycle; timer loads 1.
  - REPEAT: `step`=1 whenever timer = `REPEAT_PERIOD` (timer reloads 1); otherwise timer increments.
  - From FIRST, DELAY or REPEAT: active clean level falls → IDLE. Other clean level rises → LOCK. Neither transition emits a step.
  - LOCK: no steps. → IDLE only when both clean levels are 0.
- `step` is registered and never high for two consecutive cycles unless `REPEAT_PERIOD`=1.
- `direction` changes only on the IDLE → FIRST transition.
- `busy` = (state ≠ IDLE), registered alongside the state.
- Release never produces a step.

## Timing
- Edge k is the first edge that samples raw high, with raw held stable:
  - s2 is high after edge k+1.
  - clean is high after edge k+1+`DEBOUNCE_CYCLES`.
  - FSM is in FIRST and `step` is high after edge k+2+`DEBOUNCE_CYCLES`; with defaults, edge k+6.
- Auto-repeat: first step high in cycle p. Repeat steps are high in cycles p+`REPEAT_DELAY`, then every `REPEAT_PERIOD` cycles.
- Release latency: `DEBOUNCE_CYCLES`+2 edges to clean low, then 1 edge to IDLE.
- Reset mid-operation:
  - All state returns to reset values on the next edge; `step` is 0 in the following cycle.
  - A switch still held re-debounces from scratch, producing its first step `DEBOUNCE_CYCLES`+3 edges after reset deasserts.
- Bounce shorter than `DEBOUNCE_CYCLES` consecutive samples never changes clean.

## Configuration
- `STEP_AUTOREPEAT_EN` defined: DELAY/REPEAT behaviour as above.
- `STEP_AUTOREPEAT_EN` undefined:
  - FIRST → a hold state that emits no further steps until release (→ IDLE) or the second switch rises (→ LOCK).
  - The repeat timer and both repeat parameters are unused.
  - Exactly one step per debounced press.

## Test plan
- Reset: assert `reset` 3 cycles with both switches high → `step`=0, `direction`=1, both clean=0, `busy`=0 throughout and one cycle after release.
- Single up press:
  - Stimulus: `sw_up` first sampled high at edge 10, held 12 cycles.
  - Required: exactly one `step` pulse in the cycle after edge 16, with `direction`=1.
  - Then `busy` returns to 0 after release plus 7 edges.
- Bounce rejection: `sw_up` pattern 1,0,1,1,0,0… (never 4 consecutive highs at s2) → `up_clean` stays 0, no `step`.
- Auto-repeat down (macro defined):
  - Stimulus: `sw_down` held 40 cycles.
  - Required: steps in cycles p, p+16, p+20, p+24, p+28…, all with `direction`=0.
  - With the macro undefined: only the step in cycle p.
- Simultaneous press:
  - Stimulus: both switches rise together, then `sw_down` is released, then `sw_up`.
  - Required: no step and `busy`=1 until both clean levels are low.
  - A following lone `sw_up` press then steps normally.
- Reset mid-repeat: assert `reset` one cycle during REPEAT with `sw_up` held → `step`=0 next cycle; next step appears 7 edges after `reset` deasserts.
